pcu_stack: RTL and testbench
============================

// Module: pcu_stack
// PURPOSE
//  Parametrised program counter unit for the pipelined CPU fetch stage. Drives the instruction address.
//  Decodes control-flow opcodes from the instruction bus: two-word branches/calls and one-word returns.
//  Adds conditional branches on carry or zero, a hardware call/return stack, a fetch stall, and sticky stack error flags.
// PARAMETERS
//  DATA_W       8   instruction word width; opcode = D_BUS[DATA_W-1 -: 4]
//  ADDR_W       12  address width; PAGE_W = ADDR_W-DATA_W, where 1 <= PAGE_W <= DATA_W-4
//  STACK_DEPTH  4   return-address stack entries (>=1)
// PORTS
//  clock      in   1               rising-edge clock
//  reset      in   1               asynchronous, active-high
//  stall      in   1               1 = hold all state (address, FSM, stack, flags)
//  D_BUS      in   DATA_W          instruction word at current address
//  cflag      in   1               carry flag, valid in the cycle the opcode word is on D_BUS
//  zflag      in   1               zero flag, same timing as cflag
//  address    out  ADDR_W          current fetch address
//  taken      out  1               1-cycle pulse; address was loaded non-sequentially this edge
//  sp         out  $clog2(STACK_DEPTH+1)  current stack occupancy
//  err_ovf    out  1               sticky; CALL executed with the stack full
//  err_unf    out  1               sticky; RET executed with the stack empty
// BEHAVIOUR
//  Reset: address=0, FSM=FETCH, page_q=0, pend=NONE, sp=0, taken=0, err_ovf=0, err_unf=0; stack contents don't-care.
//  stall=1: no register changes; taken=0. All rules below apply only on non-stalled edges.
//  Opcodes (op = D_BUS[DATA_W-1 -: 4]):
//   C=JMP, B=JC (cflag=1), D=JNC (cflag=0), 8=JZ (zflag=1), A=CALL: two-word ops.
//   9=RET: one-word op. Any other op: sequential.
//  FSM FETCH:
//   Two-word op: page_q<=D_BUS[PAGE_W-1:0]; taken_q<=condition (JMP/CALL always 1); pend<=CALL or BR;
//   address<=address+1; ->OPND.
//   RET, sp>0: address<=stack[sp-1]; sp<=sp-1; taken=1.
//   RET, sp=0: address<=address+1; err_unf<=1.
//   Other op: address<=address+1.
//  FSM OPND (D_BUS = low target word); always ->FETCH:
//   taken_q=1: address<={page_q, D_BUS}; taken=1.
//   taken_q=0: address<=address+1; the operand word is skipped.
//   Taken CALL, sp<STACK_DEPTH: stack[sp]<=address+1; sp<=sp+1.
//   Taken CALL, sp=STACK_DEPTH: jump still taken; push dropped; sp unchanged; err_ovf<=1.
//   The OPND word is never decoded as an opcode.
//  Flags are sampled only in FETCH. Condition latency: 1 cycle from opcode to taken decision; load on the next edge.
//  Arithmetic: address+1 is modulo 2^ADDR_W (all-ones wraps to 0). Return address also wraps.
//  Stack is LIFO; sp never exceeds STACK_DEPTH and never underflows.
//  Errors clear only on reset.
//  Reset mid-OPND: FSM returns to FETCH at 0; the pending branch is discarded.
//  Stall in OPND: holds; decision and page_q are preserved until released.
// TESTING
//  T1 reset, then 5 non-control words -> address 0,1,2,3,4,5; taken never 1; sp=0.
//  T2 @0x010: JMP with page 0x3, then operand 0x45 -> address 0x010,0x011,0x345; taken pulses once.
//  T3 JC with cflag=0, operand 0x99 at 0x020 -> address 0x020,0x021,0x022; no taken; repeat with cflag=1 -> 0x?99 from page.
//  T4 CALL 0x2_80 at 0x100, RET at 0x280 -> 0x100,0x101,0x280, then 0x102; sp goes 0->1->0.
//  T5 STACK_DEPTH+1 nested CALLs -> last jump taken, sp=STACK_DEPTH, err_ovf=1.
//     Then STACK_DEPTH+1 RETs -> correct returns, then err_unf=1 with sequential address.
//  T6 address 0xFFF sequential -> 0x000. Stall for 3 cycles during OPND -> address/sp frozen, branch completes after release.
//     Reset asserted in OPND -> address=0, FSM=FETCH.

Source files
------------

// File: rtl/pcu_stack.sv
// Program counter unit for the fetch stage: two-word branches/calls, one-word returns,
// a hardware return-address stack, fetch stall and sticky stack error flags.
module pcu_stack #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             stall,
    input  logic [DATA_W-1:0]                D_BUS,
    input  logic                             cflag,
    input  logic                             zflag,
    output logic [ADDR_W-1:0]                address,
    output logic                             taken,
    output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
    output logic                             err_ovf,
    output logic                             err_unf
);

    localparam int unsigned PAGE_W = ADDR_W - DATA_W;
    localparam int unsigned SP_W   = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [0:0] {StFetch, StOpnd} state_e;
    typedef enum logic [1:0] {PendNone, PendBr, PendCall} pend_e;

    state_e              state_q, state_d;
    pend_e               pend_q, pend_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [PAGE_W-1:0]   page_q, page_d;
    logic                cond_q, cond_d;
    logic                taken_q, taken_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];

    logic [3:0]          op;
    logic [ADDR_W-1:0]   addr_inc;
    logic [IDX_W-1:0]    top_idx;
    logic [IDX_W-1:0]    push_idx;
    logic                push;
    logic                two_word;
    logic                cond;

    assign op       = D_BUS[DATA_W-1 -: 4];
    assign addr_inc = addr_q + ADDR_W'(1);
    assign top_idx  = IDX_W'(sp_q - SP_W'(1));
    assign push_idx = IDX_W'(sp_q);

    // Opcode decode: which ops carry an operand word, and whether the branch is taken.
    always_comb begin
        two_word = 1'b1;
        cond     = 1'b1;
        case (op)
            4'hC, 4'hA: cond = 1'b1;
            4'hB:       cond = cflag;
            4'hD:       cond = ~cflag;
            4'h8:       cond = zflag;
            default: begin
                two_word = 1'b0;
                cond     = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        page_d  = page_q;
        cond_d  = cond_q;
        taken_d = 1'b0;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        if (!stall) begin
            unique case (state_q)
                StFetch: begin
                    if (two_word) begin
                        page_d  = D_BUS[PAGE_W-1:0];
                        cond_d  = cond;
                        pend_d  = (op == 4'hA) ? PendCall : PendBr;
                        addr_d  = addr_inc;
                        state_d = StOpnd;
                    end else if (op == 4'h9) begin
                        if (sp_q != '0) begin
                            addr_d  = stack_q[top_idx];
                            sp_d    = sp_q - SP_W'(1);
                            taken_d = 1'b1;
                        end else begin
                            addr_d = addr_inc;
                            unf_d  = 1'b1;
                        end
                    end else begin
                        addr_d = addr_inc;
                    end
                end
                StOpnd: begin
                    state_d = StFetch;
                    pend_d  = PendNone;
                    if (cond_q) begin
                        addr_d  = {page_q, D_BUS};
                        taken_d = 1'b1;
                        // A full stack still takes the call; only the push is lost.
                        if (pend_q == PendCall) begin
                            if (sp_q < SP_W'(STACK_DEPTH)) begin
                                push = 1'b1;
                                sp_d = sp_q + SP_W'(1);
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                    end else begin
                        addr_d = addr_inc;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            pend_q  <= PendNone;
            addr_q  <= '0;
            page_q  <= '0;
            cond_q  <= 1'b0;
            taken_q <= 1'b0;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            page_q  <= page_d;
            cond_q  <= cond_d;
            taken_q <= taken_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return address is the word after the operand, i.e. OPND address + 1.
    always_ff @(posedge clock) begin
        if (push) begin
            stack_q[push_idx] <= addr_inc;
        end
    end

    assign address = addr_q;
    assign taken   = taken_q;
    assign sp      = sp_q;
    assign err_ovf = ovf_q;
    assign err_unf = unf_q;

endmodule

// File: tb/tb_pcu_stack.sv
// Self-checking bench for pcu_stack: a program memory feeds D_BUS and per-address flags,
// expected per-cycle state is queued ahead and popped as each edge completes.
module tb_pcu_stack;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned ADDR_W      = 12;
    localparam int unsigned STACK_DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              stall = 1'b0;
    logic [DATA_W-1:0] d_bus;
    logic              cflag;
    logic              zflag;
    logic [ADDR_W-1:0] address;
    logic              taken;
    logic [2:0]        sp;
    logic              err_ovf;
    logic              err_unf;

    logic [7:0] mem  [4096];
    logic       cmem [4096];
    logic       zmem [4096];

    typedef struct packed {
        logic        stl;
        logic [11:0] addr;
        logic        tk;
        logic [2:0]  sp;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    assign d_bus = mem[address];
    assign cflag = cmem[address];
    assign zflag = zmem[address];

    always #5 clock = ~clock;

    pcu_stack #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .stall  (stall),
        .D_BUS  (d_bus),
        .cflag  (cflag),
        .zflag  (zflag),
        .address(address),
        .taken  (taken),
        .sp     (sp),
        .err_ovf(err_ovf),
        .err_unf(err_unf)
    );

    function automatic void push_exp(input logic s, input logic [11:0] a, input logic t,
                                     input logic [2:0] p, input logic o, input logic u);
        exp_q.push_back({s, a, t, p, o, u});
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) begin
            mem[i]  = 8'h00;
            cmem[i] = 1'b0;
            zmem[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        stall = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_mem();
        do_reset();
        checks++;
        if ({address, taken, sp, err_ovf, err_unf} !== {12'h000, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state addr=%h tk=%b sp=%0d ovf=%b unf=%b required 000/0/0/0/0",
                     address, taken, sp, err_ovf, err_unf);
        end
        for (int i = 1; i <= 5; i++) push_exp(1'b0, 12'(i), 1'b0, 3'd0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            stall = e.stl;
            @(posedge clock);
            #1;
            checks++;
            if ({address, taken, sp, err_ovf, err_unf} !== {e.addr, e.tk, e.sp, e.ovf, e.unf}) begin
                failures++;
                $display("FAIL t1_seq addr=%h/%h tk=%b/%b sp=%0d/%0d ovf=%b/%b unf=%b/%b",
                         address, e.addr, taken, e.tk, sp, e.sp, err_ovf, e.ovf, err_unf, e.unf);
            end
        end
    endtask

    task automatic test_jmp();
        clear_mem();
        mem[12'h000] = 8'hC0; mem[12'h001] = 8'h10;
        mem[12'h010] = 8'hC3; mem[12'h011] = 8'h45;
        do_reset();
        push_exp(1'b0, 12'h001, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h010, 1'b1, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h011, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h345, 1'b1, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h346, 1'b0, 3'd0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            stall = e.stl;
            @(posedge clock);
            #1;
            checks++;
            if ({address, taken, sp, err_ovf, err_unf} !== {e.addr, e.tk, e.sp, e.ovf, e.unf}) begin
                failures++;
                $display("FAIL t2_jmp addr=%h/%h tk=%b/%b sp=%0d/%0d ovf=%b/%b unf=%b/%b",
                         address, e.addr, taken, e.tk, sp, e.sp, err_ovf, e.ovf, err_unf, e.unf);
            end
        end
    endtask

    task automatic test_cond();
        clear_mem();
        mem[12'h000] = 8'hC0; mem[12'h001] = 8'h20;
        mem[12'h020] = 8'hB0; mem[12'h021] = 8'h99;                     // JC, c=0: skip
        mem[12'h023] = 8'hB5; mem[12'h024] = 8'h99; cmem[12'h023] = 1'b1; // JC, c=1: take
        mem[12'h599] = 8'hD0; mem[12'h59A] = 8'h40; cmem[12'h599] = 1'b1; // JNC, c=1: skip
        mem[12'h59B] = 8'h87; mem[12'h59C] = 8'h10; zmem[12'h59B] = 1'b1; // JZ, z=1: take
        do_reset();
        push_exp(1'b0, 12'h001, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h020, 1'b1, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h021, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h022, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h023, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h024, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h599, 1'b1, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h59A, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h59B, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h59C, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h710, 1'b1, 3'd0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            stall = e.stl;
            @(posedge clock);
            #1;
            checks++;
            if ({address, taken, sp, err_ovf, err_unf} !== {e.addr, e.tk, e.sp, e.ovf, e.unf}) begin
                failures++;
                $display("FAIL t3_cond addr=%h/%h tk=%b/%b sp=%0d/%0d ovf=%b/%b unf=%b/%b",
                         address, e.addr, taken, e.tk, sp, e.sp, err_ovf, e.ovf, err_unf, e.unf);
            end
        end
    endtask

    task automatic test_call_ret();
        clear_mem();
        mem[12'h000] = 8'hC1; mem[12'h001] = 8'h00;
        mem[12'h100] = 8'hA2; mem[12'h101] = 8'h80;
        mem[12'h280] = 8'h90;
        do_reset();
        push_exp(1'b0, 12'h001, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h100, 1'b1, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h101, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h280, 1'b1, 3'd1, 1'b0, 1'b0);
        push_exp(1'b0, 12'h102, 1'b1, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h103, 1'b0, 3'd0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            stall = e.stl;
            @(posedge clock);
            #1;
            checks++;
            if ({address, taken, sp, err_ovf, err_unf} !== {e.addr, e.tk, e.sp, e.ovf, e.unf}) begin
                failures++;
                $display("FAIL t4_call_ret addr=%h/%h tk=%b/%b sp=%0d/%0d ovf=%b/%b unf=%b/%b",
                         address, e.addr, taken, e.tk, sp, e.sp, err_ovf, e.ovf, err_unf, e.unf);
            end
        end
    endtask

    task automatic test_stack_errors();
        clear_mem();
        // Call chain 0x000 -> 0x100 -> ... -> 0x500; the fifth push overflows.
        for (int k = 0; k <= STACK_DEPTH; k++) begin
            mem[k * 256]     = 8'(8'hA0 | (k + 1));
            mem[k * 256 + 1] = 8'h00;
        end
        mem[12'h500] = 8'h90;
        mem[12'h302] = 8'h90;
        mem[12'h202] = 8'h90;
        mem[12'h102] = 8'h90;
        mem[12'h002] = 8'h90;
        do_reset();
        push_exp(1'b0, 12'h001, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h100, 1'b1, 3'd1, 1'b0, 1'b0);
        push_exp(1'b0, 12'h101, 1'b0, 3'd1, 1'b0, 1'b0);
        push_exp(1'b0, 12'h200, 1'b1, 3'd2, 1'b0, 1'b0);
        push_exp(1'b0, 12'h201, 1'b0, 3'd2, 1'b0, 1'b0);
        push_exp(1'b0, 12'h300, 1'b1, 3'd3, 1'b0, 1'b0);
        push_exp(1'b0, 12'h301, 1'b0, 3'd3, 1'b0, 1'b0);
        push_exp(1'b0, 12'h400, 1'b1, 3'd4, 1'b0, 1'b0);
        push_exp(1'b0, 12'h401, 1'b0, 3'd4, 1'b0, 1'b0);
        push_exp(1'b0, 12'h500, 1'b1, 3'd4, 1'b1, 1'b0);
        push_exp(1'b0, 12'h302, 1'b1, 3'd3, 1'b1, 1'b0);
        push_exp(1'b0, 12'h202, 1'b1, 3'd2, 1'b1, 1'b0);
        push_exp(1'b0, 12'h102, 1'b1, 3'd1, 1'b1, 1'b0);
        push_exp(1'b0, 12'h002, 1'b1, 3'd0, 1'b1, 1'b0);
        push_exp(1'b0, 12'h003, 1'b0, 3'd0, 1'b1, 1'b1);
        push_exp(1'b0, 12'h004, 1'b0, 3'd0, 1'b1, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            stall = e.stl;
            @(posedge clock);
            #1;
            checks++;
            if ({address, taken, sp, err_ovf, err_unf} !== {e.addr, e.tk, e.sp, e.ovf, e.unf}) begin
                failures++;
                $display("FAIL t5_stack addr=%h/%h tk=%b/%b sp=%0d/%0d ovf=%b/%b unf=%b/%b",
                         address, e.addr, taken, e.tk, sp, e.sp, err_ovf, e.ovf, err_unf, e.unf);
            end
        end
    endtask

    task automatic test_wrap_stall_reset();
        clear_mem();
        mem[12'h000] = 8'hCF; mem[12'h001] = 8'hFE;
        do_reset();
        push_exp(1'b0, 12'h001, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'hFFE, 1'b1, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'hFFF, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h000, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h001, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b1, 12'h001, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b1, 12'h001, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b1, 12'h001, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'hFFE, 1'b1, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'hFFF, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h000, 1'b0, 3'd0, 1'b0, 1'b0);
        push_exp(1'b0, 12'h001, 1'b0, 3'd0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            stall = e.stl;
            @(posedge clock);
            #1;
            checks++;
            if ({address, taken, sp, err_ovf, err_unf} !== {e.addr, e.tk, e.sp, e.ovf, e.unf}) begin
                failures++;
                $display("FAIL t6_wrap_stall addr=%h/%h tk=%b/%b sp=%0d/%0d ovf=%b/%b unf=%b/%b",
                         address, e.addr, taken, e.tk, sp, e.sp, err_ovf, e.ovf, err_unf, e.unf);
            end
        end
        // Now in OPND at 0x001; an asynchronous reset must clear address at once.
        stall = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (address !== 12'h000 || taken !== 1'b0) begin
            failures++;
            $display("FAIL t6_async_reset addr=%h tk=%b required 000/0", address, taken);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        // A leftover OPND state would jump to 0xFCF instead of fetching the JMP at 0.
        @(posedge clock);
        #1;
        checks++;
        if (address !== 12'h001 || taken !== 1'b0) begin
            failures++;
            $display("FAIL t6_reset_opnd addr=%h tk=%b required 001/0", address, taken);
        end
    endtask

    initial begin
        test_reset();
        test_jmp();
        test_cond();
        test_call_ret();
        test_stack_errors();
        test_wrap_stall_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
